// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - run/stop/clear/mode controller merging button pulses and UART commands
// Optional feature: CMD_ECHO_EN echoes accepted UART command bytes into the TX FIFO.
module counter_cmd_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       rx_empty,
  input  logic [7:0] rx_rdata,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_wdata,
  output logic       o_tick,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} run_state_t;
  typedef enum logic {RX_IDLE = 1'b0, RX_WAIT = 1'b1} rx_state_t;

  run_state_t    run_state;
  rx_state_t     rx_state;
  logic [DW-1:0] div_cnt;

  logic any_btn;
  logic is_run_byte, is_clear_byte, is_mode_byte;
  logic cmd_run, cmd_clear, cmd_mode;
  logic stay_run;

  assign any_btn = btn_run | btn_clear | btn_mode;

  // Pop is combinational so the FWFT head byte is consumed in the cycle it is decoded.
  assign rx_pop = !rst && (rx_state == RX_IDLE) && !rx_empty && !any_btn;

  assign is_run_byte   = (rx_rdata == 8'h52) || (rx_rdata == 8'h72);
  assign is_clear_byte = (rx_rdata == 8'h43) || (rx_rdata == 8'h63);
  assign is_mode_byte  = (rx_rdata == 8'h4D) || (rx_rdata == 8'h6D);

  assign cmd_run   = btn_run   | (rx_pop & is_run_byte);
  assign cmd_clear = btn_clear | (rx_pop & is_clear_byte);
  assign cmd_mode  = btn_mode  | (rx_pop & is_mode_byte);

  // The divider only advances on cycles that stay in RUN, so a tick can never land in STOP.
  assign stay_run = (run_state == RUN) && !cmd_run && !cmd_clear;

  assign o_running = (run_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_state <= STOP;
      rx_state  <= RX_IDLE;
      div_cnt   <= '0;
      o_tick    <= 1'b0;
      o_clear   <= 1'b0;
      o_mode    <= 1'b0;
    end else begin
      rx_state <= rx_pop ? RX_WAIT : RX_IDLE;
      o_clear  <= cmd_clear;
      o_tick   <= 1'b0;
      if (cmd_clear) begin
        run_state <= STOP;
        div_cnt   <= '0;
      end else begin
        if (cmd_run) begin
          run_state <= (run_state == RUN) ? STOP : RUN;
        end
        if (stay_run) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            o_tick  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      end
      if (cmd_mode) begin
        o_mode <= !o_mode;
      end
    end
  end

`ifdef CMD_ECHO_EN
  logic       echo_pend;
  logic [7:0] echo_byte;

  // A full TX FIFO drops the echo rather than stalling command processing.
  assign tx_push  = echo_pend & ~tx_full;
  assign tx_wdata = echo_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_pend <= 1'b0;
      echo_byte <= 8'h00;
    end else begin
      echo_pend <= rx_pop & (is_run_byte | is_clear_byte | is_mode_byte);
      if (rx_pop) begin
        echo_byte <= rx_rdata;
      end
    end
  end
`else
  logic unused_tx_full;

  assign unused_tx_full = tx_full;
  assign tx_push        = 1'b0;
  assign tx_wdata       = 8'h00;
`endif

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - self-checking bench for counter_cmd_ctrl with a behavioural reference model
module tb_counter_cmd_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_rdata = 8'h00;
  logic       rx_pop;
  logic       tx_full = 1'b0;
  logic       tx_push;
  logic [7:0] tx_wdata;
  logic       o_tick, o_clear, o_mode, o_running;

  counter_cmd_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_pop(rx_pop),
    .tx_full(tx_full), .tx_push(tx_push), .tx_wdata(tx_wdata),
    .o_tick(o_tick), .o_clear(o_clear), .o_mode(o_mode), .o_running(o_running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo[$];

  // Reference model: command semantics expressed directly, phase kept as a count of RUN cycles.
  bit         m_run, m_mode, m_wait, m_clear, m_tick, m_pend;
  logic [7:0] m_pend_byte;
  int         m_steady;

  int tick_count, pop_count, push_count, clear_count;

  function automatic bit is_r(input logic [7:0] b);
    return (b == "R") || (b == "r");
  endfunction
  function automatic bit is_c(input logic [7:0] b);
    return (b == "C") || (b == "c");
  endfunction
  function automatic bit is_m(input logic [7:0] b);
    return (b == "M") || (b == "m");
  endfunction

  task automatic cycle(input logic r, input logic b_run, input logic b_clr,
                       input logic b_mode, input logic full);
    bit         exp_pop, exp_push, c_run, c_clr, c_mode, popped;
    logic [7:0] b;
    rst       = r;
    btn_run   = b_run;
    btn_clear = b_clr;
    btn_mode  = b_mode;
    tx_full   = full;
    rx_empty  = (fifo.size() == 0);
    rx_rdata  = rx_empty ? 8'h00 : fifo[0];
    #1;
    exp_pop = !r && !m_wait && (fifo.size() > 0) && !(b_run || b_clr || b_mode);
    checks++;
    if (rx_pop !== exp_pop) begin
      failures++;
      $display("FAIL rx_pop t=%0t got=%b exp=%b", $time, rx_pop, exp_pop);
    end
`ifdef CMD_ECHO_EN
    exp_push = m_pend && !full;
`else
    exp_push = 1'b0;
`endif
    checks++;
    if (tx_push !== exp_push) begin
      failures++;
      $display("FAIL tx_push t=%0t got=%b exp=%b", $time, tx_push, exp_push);
    end
`ifdef CMD_ECHO_EN
    if (exp_push) begin
      checks++;
      if (tx_wdata !== m_pend_byte) begin
        failures++;
        $display("FAIL tx_wdata t=%0t got=%h exp=%h", $time, tx_wdata, m_pend_byte);
      end
    end
`else
    checks++;
    if (tx_wdata !== 8'h00) begin
      failures++;
      $display("FAIL tx_wdata_tied t=%0t got=%h exp=00", $time, tx_wdata);
    end
`endif
    if (tx_push === 1'b1) push_count++;
    b      = rx_rdata;
    c_run  = b_run || (exp_pop && is_r(b));
    c_clr  = b_clr || (exp_pop && is_c(b));
    c_mode = b_mode || (exp_pop && is_m(b));
    if (r) begin
      m_run = 0; m_mode = 0; m_wait = 0; m_clear = 0; m_tick = 0; m_pend = 0; m_steady = 0;
    end else begin
      m_clear = c_clr;
      m_tick  = 0;
      if (c_clr) begin
        m_run = 0;
        m_steady = 0;
      end else if (c_run) begin
        m_run = !m_run;
      end else if (m_run) begin
        m_steady++;
        m_tick = (m_steady % DIV == 0);
      end
      if (c_mode) m_mode = !m_mode;
      m_wait      = exp_pop;
      m_pend      = exp_pop && (is_r(b) || is_c(b) || is_m(b));
      m_pend_byte = b;
    end
    popped = (rx_pop === 1'b1);
    @(posedge clk);
    #1;
    if (popped && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pop_count++;
    end
    checks++;
    if (o_running !== m_run) begin
      failures++;
      $display("FAIL o_running t=%0t got=%b exp=%b", $time, o_running, m_run);
    end
    checks++;
    if (o_mode !== m_mode) begin
      failures++;
      $display("FAIL o_mode t=%0t got=%b exp=%b", $time, o_mode, m_mode);
    end
    checks++;
    if (o_clear !== m_clear) begin
      failures++;
      $display("FAIL o_clear t=%0t got=%b exp=%b", $time, o_clear, m_clear);
    end
    checks++;
    if (o_tick !== m_tick) begin
      failures++;
      $display("FAIL o_tick t=%0t got=%b exp=%b", $time, o_tick, m_tick);
    end
    if (o_tick === 1'b1) tick_count++;
    if (o_clear === 1'b1) clear_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    fifo.delete();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    fifo.delete();
    fifo.push_back("r");
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (fifo.size() != 1) begin
      failures++;
      $display("FAIL reset_no_pop fifo_size=%0d exp=1", fifo.size());
    end
    fifo.delete();
  endtask

  task automatic test_run_tick();
    int t0, first;
    do_reset();
    cycle(0, 1, 0, 0, 0);
    t0 = tick_count;
    idle(35);
    checks++;
    if (tick_count - t0 != 3) begin
      failures++;
      $display("FAIL run_tick_count got=%0d exp=3", tick_count - t0);
    end
    cycle(0, 1, 0, 0, 0);
    t0 = tick_count;
    idle(15);
    checks++;
    if (tick_count != t0 || o_running !== 1'b0) begin
      failures++;
      $display("FAIL stop_ticks got=%0d running=%b exp=0/0", tick_count - t0, o_running);
    end
    cycle(0, 1, 0, 0, 0);
    t0 = tick_count;
    first = -1;
    for (int i = 1; i <= DIV; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (first < 0 && tick_count != t0) first = i;
    end
    checks++;
    if (first != DIV - (35 % DIV)) begin
      failures++;
      $display("FAIL resume_phase got=%0d exp=%0d", first, DIV - (35 % DIV));
    end
  endtask

  task automatic test_uart();
    int p0, c0;
    do_reset();
    fifo.push_back("r"); fifo.push_back("m"); fifo.push_back("x"); fifo.push_back("C");
    p0 = pop_count;
    c0 = clear_count;
    idle(10);
    checks++;
    if (pop_count - p0 != 4 || clear_count - c0 != 1 || o_mode !== 1'b1 || o_running !== 1'b0) begin
      failures++;
      $display("FAIL uart_seq pops=%0d clears=%0d mode=%b run=%b exp=4/1/1/0",
               pop_count - p0, clear_count - c0, o_mode, o_running);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    fifo.push_back("m");
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (fifo.size() != 1 || o_mode !== 1'b1) begin
      failures++;
      $display("FAIL arb_button_first fifo=%0d mode=%b exp=1/1", fifo.size(), o_mode);
    end
    idle(3);
    checks++;
    if (fifo.size() != 0 || o_mode !== 1'b0) begin
      failures++;
      $display("FAIL arb_final fifo=%0d mode=%b exp=0/0", fifo.size(), o_mode);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_reset();
    cycle(0, 1, 0, 0, 0);
    idle(13);
    cycle(0, 1, 1, 0, 0);
    checks++;
    if (o_clear !== 1'b1 || o_running !== 1'b0 || o_tick !== 1'b0) begin
      failures++;
      $display("FAIL run_clear clear=%b run=%b tick=%b exp=1/0/0", o_clear, o_running, o_tick);
    end
    cycle(0, 1, 0, 0, 0);
    t0 = tick_count;
    idle(DIV - 1);
    checks++;
    if (tick_count != t0) begin
      failures++;
      $display("FAIL divider_restart early_ticks=%0d exp=0", tick_count - t0);
    end
    idle(1);
    checks++;
    if (tick_count - t0 != 1) begin
      failures++;
      $display("FAIL divider_restart ticks=%0d exp=1", tick_count - t0);
    end
  endtask

  task automatic test_echo();
    int p0, exp_pushes;
    do_reset();
    p0 = push_count;
    fifo.push_back("M");
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    fifo.push_back("M");
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    fifo.push_back("q");
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
`ifdef CMD_ECHO_EN
    exp_pushes = 1;
`else
    exp_pushes = 0;
`endif
    checks++;
    if (push_count - p0 != exp_pushes || o_mode !== 1'b0) begin
      failures++;
      $display("FAIL echo pushes=%0d mode=%b exp=%0d/0", push_count - p0, o_mode, exp_pushes);
    end
  endtask

  task automatic test_mid_reset();
    int t0;
    do_reset();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    idle(3);
    fifo.push_back("c");
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (o_running !== 1'b0 || o_mode !== 1'b0 || o_clear !== 1'b0 || o_tick !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset run=%b mode=%b clear=%b tick=%b exp=0000",
               o_running, o_mode, o_clear, o_tick);
    end
    t0 = tick_count;
    idle(2 * DIV);
    checks++;
    if (tick_count != t0) begin
      failures++;
      $display("FAIL mid_reset_ticks got=%0d exp=0", tick_count - t0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[7];
    pool = '{"R", "r", "C", "c", "M", "m", 8'h00};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 6);
        fifo.push_back(k == 6 ? 8'($urandom) : pool[k]);
      end
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    m_run = 0; m_mode = 0; m_wait = 0; m_clear = 0; m_tick = 0; m_pend = 0;
    m_pend_byte = 8'h00; m_steady = 0;
    tick_count = 0; pop_count = 0; push_count = 0; clear_count = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_run_tick();
    test_uart();
    test_arbitration();
    test_back_to_back();
    test_echo();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
